// File: rtl/oddr_x2_serializer_pkg.sv
// Shared gearing package for the 4:1 output serializer and its 1:4 input gearing.
// Holds the serializer state encoding, the gear width and the bit-order
// constants, so both directions agree on which parallel bit goes out first.
package oddr_x2_serializer_pkg;

    localparam int unsigned GearWidth = 4;

    // Serializer control state.
    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } gear_state_e;

    // Position of each parallel bit in the shift register; position 0 is sent
    // first. The input gearing returns position n on the matching output.
    localparam int unsigned PosA0 = 0;
    localparam int unsigned PosB0 = 1;
    localparam int unsigned PosA1 = 2;
    localparam int unsigned PosB1 = 3;

    // Pack the four parallel bits into transmit order.
    function automatic logic [GearWidth-1:0] gear_pack(input logic a0, input logic b0,
                                                       input logic a1, input logic b1);
        logic [GearWidth-1:0] w;
        w        = '0;
        w[PosA0] = a0;
        w[PosB0] = b0;
        w[PosA1] = a1;
        w[PosB1] = b1;
        return w;
    endfunction

endpackage

// File: rtl/oddr_x2_serializer.sv
// 4:1 serializer with a one-word holding register and a ready/valid input.
// Each accepted word {DA0, DB0, DA1, DB1} is sent on Q in the order
// DA0, DB0, DA1, DB1, one bit per enabled SCLK edge; FRM marks the first bit.
// Words queued in the holding register follow without an idle gap.
//
// Ports:
//   SCLK            in   clock, all state updates on rising edge
//   RST             in   synchronous active-high reset
//   CE              in   clock enable; 0 freezes all state and handshakes
//   DA0/DA1/DB0/DB1 in   parallel word
//   VALID           in   parallel word present
//   READY           out  holding register can accept a word
//   Q               out  registered serial data (IDLE_BIT when nothing is sent)
//   FRM             out  registered, high while Q carries the first bit of a word
module oddr_x2_serializer
    import oddr_x2_serializer_pkg::*;
#(
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic SCLK,
    input  logic RST,
    input  logic CE,
    input  logic DA0,
    input  logic DA1,
    input  logic DB0,
    input  logic DB1,
    input  logic VALID,
    output logic READY,
    output logic Q,
    output logic FRM
);

    gear_state_e          state_q, state_d;
    logic [GearWidth-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [GearWidth-1:0] sr_q, sr_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 q_q, q_d;
    logic                 frm_q, frm_d;

    logic                 load_word;
    logic                 shift_bit;
    logic                 go_idle;
    logic                 accept;

    // READY depends only on registered state and reset, never on VALID.
    assign READY  = ~RST & ~hold_full_q;
    assign accept = CE & VALID & READY;

    // State register.
    always_ff @(posedge SCLK) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-edge action decode.
    always_comb begin
        state_d   = state_q;
        load_word = 1'b0;
        shift_bit = 1'b0;
        go_idle   = 1'b0;
        if (CE) begin
            case (state_q)
                StIdle: begin
                    if (hold_full_q) begin
                        load_word = 1'b1;
                        state_d   = StShift;
                    end else begin
                        go_idle = 1'b1;
                    end
                end
                StShift: begin
                    if (cnt_q != 2'd0) begin
                        shift_bit = 1'b1;
                    end else if (hold_full_q) begin
                        // Word exhausted with the next one waiting: reload without a gap.
                        load_word = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath and output next values.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        q_d         = q_q;
        frm_d       = frm_q;

        if (load_word) begin
            q_d         = hold_q[PosA0];
            frm_d       = 1'b1;
            sr_d        = hold_q;
            cnt_d       = 2'd1;
            hold_full_d = 1'b0;
        end
        if (shift_bit) begin
            q_d   = sr_q[cnt_q];
            frm_d = 1'b0;
            cnt_d = cnt_q + 2'd1;
        end
        if (go_idle) begin
            q_d   = IDLE_BIT;
            frm_d = 1'b0;
        end
        // accept needs READY, so it never coincides with load_word clearing the hold.
        if (accept) begin
            hold_d      = gear_pack(DA0, DB0, DA1, DB1);
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge SCLK) begin
        if (RST) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sr_q        <= '0;
            cnt_q       <= 2'd0;
            q_q         <= IDLE_BIT;
            frm_q       <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            frm_q       <= frm_d;
        end
    end

    assign Q   = q_q;
    assign FRM = frm_q;

endmodule
